// File: rtl/byteswap_axi_read_master.sv
// AXI4 read master feeding the byteswap stage: fetches a byte range as INCR bursts
// and forwards the returned words in order as an AXI4-Stream with tlast on the final word.
module byteswap_axi_read_master #(
    parameter int C_M_AXI_ADDR_WIDTH = 64,
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int C_XFER_SIZE_WIDTH  = 32,
    parameter int C_BURST_LEN        = 16,
    parameter int C_MAX_OUTSTANDING  = 4
) (
    input  logic                          ap_clk,
    input  logic                          areset,
    input  logic                          ctrl_start,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0] ctrl_addr,
    input  logic [C_XFER_SIZE_WIDTH-1:0]  ctrl_xfer_size,
    output logic                          ctrl_busy,
    output logic                          ctrl_done,
    output logic                          m_axi_arvalid,
    input  logic                          m_axi_arready,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]                    m_axi_arlen,
    output logic [2:0]                    m_axi_arsize,
    output logic [1:0]                    m_axi_arburst,
    input  logic                          m_axi_rvalid,
    output logic                          m_axi_rready,
    input  logic [C_M_AXI_DATA_WIDTH-1:0] m_axi_rdata,
    input  logic                          m_axi_rlast,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic [C_M_AXI_DATA_WIDTH-1:0] m_axis_tdata,
    output logic                          m_axis_tlast
);

    localparam int AW       = C_M_AXI_ADDR_WIDTH;
    localparam int XW       = C_XFER_SIZE_WIDTH;
    localparam int BPB      = C_M_AXI_DATA_WIDTH / 8;
    localparam int LOG2_BPB = $clog2(BPB);
    localparam int OW       = $clog2(C_MAX_OUTSTANDING + 1);

    localparam logic [AW-1:0] BURST_BYTES = AW'(C_BURST_LEN * BPB);
    localparam logic [AW-1:0] ALIGN_MASK  = ~AW'(BPB - 1);
    localparam logic [XW-1:0] BURST_BEATS = XW'(C_BURST_LEN);
    localparam logic [OW-1:0] MAX_OUT     = OW'(C_MAX_OUTSTANDING);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t        state;
    logic [XW-1:0] n_beats;
    logic [XW-1:0] req_left;
    logic [XW-1:0] beat_cnt;
    logic [OW-1:0] outstanding;

    logic          run;
    logic          ar_hs;
    logic          r_hs;
    logic          r_last_hs;
    logic          last_hs;
    logic [XW:0]   size_round;
    logic [XW-1:0] start_beats;
    logic [XW-1:0] ar_beats;
    logic [XW-1:0] req_after;
    logic [OW-1:0] out_after;

    function automatic logic [7:0] burst_len(input logic [XW-1:0] beats);
        return (beats >= BURST_BEATS) ? 8'(C_BURST_LEN - 1) : 8'(beats - XW'(1));
    endfunction

    assign m_axi_arsize  = 3'(LOG2_BPB);
    assign m_axi_arburst = 2'b01;

    assign run           = (state == S_RUN);
    assign m_axis_tvalid = m_axi_rvalid & run;
    assign m_axi_rready  = m_axis_tready & run;
    assign m_axis_tdata  = m_axi_rdata;
    assign m_axis_tlast  = run && (beat_cnt == n_beats - XW'(1));

    assign ar_hs     = m_axi_arvalid & m_axi_arready;
    assign r_hs      = m_axi_rvalid & m_axi_rready;
    assign r_last_hs = r_hs & m_axi_rlast;
    assign last_hs   = r_hs & m_axis_tlast;

    // Round up in one extra bit so a byte count near the top of the range cannot wrap.
    assign size_round  = {1'b0, ctrl_xfer_size} + (XW + 1)'(BPB - 1);
    assign start_beats = XW'(size_round >> LOG2_BPB);

    assign ar_beats  = XW'(m_axi_arlen) + XW'(1);
    assign req_after = ar_hs ? (req_left - ar_beats) : req_left;

    always_comb begin
        out_after = outstanding;
        if (ar_hs && !r_last_hs)
            out_after = outstanding + OW'(1);
        else if (!ar_hs && r_last_hs)
            out_after = outstanding - OW'(1);
    end

    always_ff @(posedge ap_clk) begin
        if (areset) begin
            state         <= S_IDLE;
            n_beats       <= '0;
            req_left      <= '0;
            beat_cnt      <= '0;
            outstanding   <= '0;
            m_axi_arvalid <= 1'b0;
            m_axi_araddr  <= '0;
            m_axi_arlen   <= '0;
            ctrl_busy     <= 1'b0;
            ctrl_done     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    ctrl_done <= 1'b0;
                    if (ctrl_start) begin
                        n_beats      <= start_beats;
                        req_left     <= start_beats;
                        beat_cnt     <= '0;
                        outstanding  <= '0;
                        m_axi_araddr <= ctrl_addr & ALIGN_MASK;
                        ctrl_busy    <= 1'b1;
                        if (start_beats != '0) begin
                            m_axi_arlen   <= burst_len(start_beats);
                            m_axi_arvalid <= 1'b1;
                            state         <= S_RUN;
                        end else begin
                            state <= S_DONE;
                        end
                    end
                end
                S_RUN: begin
                    req_left    <= req_after;
                    outstanding <= out_after;
                    if (ar_hs) begin
                        m_axi_araddr <= m_axi_araddr + BURST_BYTES;
                        if (req_after != '0)
                            m_axi_arlen <= burst_len(req_after);
                    end
                    if (r_hs)
                        beat_cnt <= beat_cnt + XW'(1);
                    m_axi_arvalid <= (req_after != '0) && (out_after < MAX_OUT);
                    if (last_hs) begin
                        m_axi_arvalid <= 1'b0;
                        ctrl_busy     <= 1'b0;
                        ctrl_done     <= 1'b1;
                        state         <= S_DONE;
                    end
                end
                S_DONE: begin
                    // Arrived with done already raised from RUN, or with a zero-length job still busy.
                    if (ctrl_done) begin
                        ctrl_done <= 1'b0;
                        state     <= S_IDLE;
                    end else begin
                        ctrl_done <= 1'b1;
                        ctrl_busy <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_byteswap_axi_read_master.sv
// Directed bench for byteswap_axi_read_master: vector table of transfers against a
// simple in-order memory slave, plus hand-written zero-size and mid-transfer reset cases.
module tb_byteswap_axi_read_master;

    logic        ap_clk = 1'b0;
    logic        areset = 1'b1;
    logic        ctrl_start = 1'b0;
    logic [63:0] ctrl_addr = '0;
    logic [31:0] ctrl_xfer_size = '0;
    logic        ctrl_busy, ctrl_done;
    logic        m_axi_arvalid;
    logic        m_axi_arready = 1'b0;
    logic [63:0] m_axi_araddr;
    logic [7:0]  m_axi_arlen;
    logic [2:0]  m_axi_arsize;
    logic [1:0]  m_axi_arburst;
    logic        m_axi_rvalid = 1'b0;
    logic        m_axi_rready;
    logic [31:0] m_axi_rdata = '0;
    logic        m_axi_rlast = 1'b0;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b0;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tlast;

    byteswap_axi_read_master dut (
        .ap_clk(ap_clk), .areset(areset),
        .ctrl_start(ctrl_start), .ctrl_addr(ctrl_addr), .ctrl_xfer_size(ctrl_xfer_size),
        .ctrl_busy(ctrl_busy), .ctrl_done(ctrl_done),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
        .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rlast(m_axi_rlast),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast)
    );

    always #5 ap_clk = ~ap_clk;

    typedef struct {
        logic [63:0] addr;
        logic [31:0] size;
        int          hold;
        bit          toggle;
        bit          mid;
        int          exp_beats;
        int          exp_ars;
        int          exp_last_len;
    } vec_t;

    int checks = 0;
    int errors = 0;

    logic [63:0] q_addr[$];
    int          q_len[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] pat(input logic [63:0] a);
        return {a[15:0] ^ 16'hBEEF, a[15:0]};
    endfunction

    task automatic run_xfer(input vec_t v);
        logic [63:0] base;
        int bib, ar_n, beats, last_k, done_k, done_cnt, last_len, rem, exp_len;
        base = v.addr & ~64'h3;
        bib = 0; ar_n = 0; beats = 0; last_k = -10; done_k = -1; done_cnt = 0; last_len = -1;
        q_addr.delete();
        q_len.delete();
        for (int k = 0; k < 3000; k++) begin
            @(negedge ap_clk);
            ctrl_start = (k == 0) || (v.mid && k == 10);
            if (k == 0) begin
                ctrl_addr = v.addr;
                ctrl_xfer_size = v.size;
            end
            if (v.mid && k == 10) begin
                ctrl_addr = 64'h9000;
                ctrl_xfer_size = 32'd8;
            end
            m_axi_arready = 1'b1;
            m_axis_tready = v.toggle ? ((k % 2) == 0) : 1'b1;
            if (q_addr.size() > 0 && k > v.hold) begin
                m_axi_rvalid = 1'b1;
                m_axi_rdata  = pat(q_addr[0] + 64'(4 * bib));
                m_axi_rlast  = (bib == q_len[0]);
            end else begin
                m_axi_rvalid = 1'b0;
                m_axi_rdata  = '0;
                m_axi_rlast  = 1'b0;
            end
            #1;
            if (k == 1) begin
                chk("start_busy", ctrl_busy, 1);
                chk("start_arvalid", m_axi_arvalid, 1);
            end
            if (m_axi_arvalid && m_axi_arready) begin
                if (ar_n < v.exp_ars) begin
                    rem = v.exp_beats - 16 * ar_n;
                    exp_len = (rem >= 16 ? 16 : rem) - 1;
                    chk("araddr", m_axi_araddr, base + 64'(64 * ar_n));
                    chk("arlen", m_axi_arlen, exp_len);
                end else begin
                    chk("extra_ar", ar_n, v.exp_ars - 1);
                end
                q_addr.push_back(m_axi_araddr);
                q_len.push_back(int'(m_axi_arlen));
                last_len = int'(m_axi_arlen);
                ar_n++;
            end
            if (v.hold > 0 && k == v.hold) begin
                chk("ar_limit_count", ar_n, 4);
                chk("ar_limit_arvalid", m_axi_arvalid, 0);
            end
            if (ctrl_busy) chk("rready_mirror", m_axi_rready, m_axis_tready);
            if (m_axi_rvalid && m_axi_rready) begin
                chk("tvalid", m_axis_tvalid, 1);
                chk("tdata", m_axis_tdata, pat(base + 64'(4 * beats)));
                chk("tlast", m_axis_tlast, beats == v.exp_beats - 1);
                beats++;
                if (beats == v.exp_beats) last_k = k;
                if (m_axi_rlast) begin
                    void'(q_addr.pop_front());
                    void'(q_len.pop_front());
                    bib = 0;
                end else begin
                    bib++;
                end
            end
            if (k == last_k) chk("busy_at_last", ctrl_busy, 1);
            if (ctrl_done) begin
                done_cnt++;
                if (done_k < 0) done_k = k;
                chk("done_busy", ctrl_busy, 0);
            end
            if (done_k >= 0 && k >= done_k + 2) break;
        end
        ctrl_start = 1'b0;
        m_axi_rvalid = 1'b0;
        m_axi_rlast = 1'b0;
        if (done_k < 0) begin
            checks++;
            errors++;
            $display("FAIL timeout: no ctrl_done for addr 0x%0h size %0d", v.addr, v.size);
        end
        chk("beat_count", beats, v.exp_beats);
        chk("ar_count", ar_n, v.exp_ars);
        chk("last_arlen", last_len, v.exp_last_len);
        chk("done_pulses", done_cnt, 1);
        chk("done_latency", done_k, last_k + 1);
    endtask

    vec_t vecs[5];

    initial begin
        vecs[0] = '{addr: 64'h1000, size: 32'd64,  hold: 0,  toggle: 0, mid: 0, exp_beats: 16,  exp_ars: 1, exp_last_len: 15};
        vecs[1] = '{addr: 64'h2000, size: 32'd100, hold: 0,  toggle: 0, mid: 1, exp_beats: 25,  exp_ars: 2, exp_last_len: 8};
        vecs[2] = '{addr: 64'h3000, size: 32'd512, hold: 20, toggle: 1, mid: 0, exp_beats: 128, exp_ars: 8, exp_last_len: 15};
        vecs[3] = '{addr: 64'h5002, size: 32'd5,   hold: 0,  toggle: 0, mid: 0, exp_beats: 2,   exp_ars: 1, exp_last_len: 1};
        vecs[4] = '{addr: 64'h6000, size: 32'd1,   hold: 0,  toggle: 1, mid: 0, exp_beats: 1,   exp_ars: 1, exp_last_len: 0};

        repeat (3) @(negedge ap_clk);
        areset = 1'b0;
        #1;
        chk("rst_arvalid", m_axi_arvalid, 0);
        chk("rst_busy", ctrl_busy, 0);
        chk("rst_done", ctrl_done, 0);
        chk("rst_araddr", m_axi_araddr, 0);
        chk("rst_arlen", m_axi_arlen, 0);
        chk("rst_tlast", m_axis_tlast, 0);
        chk("arsize", m_axi_arsize, 2);
        chk("arburst", m_axi_arburst, 1);

        // Zero-size job: busy only in T+1, done in T+2, stream gated off throughout.
        for (int k = 0; k < 4; k++) begin
            @(negedge ap_clk);
            ctrl_start = (k == 0);
            ctrl_addr = 64'hA000;
            ctrl_xfer_size = 32'd0;
            m_axi_rvalid = 1'b1;
            m_axis_tready = 1'b1;
            #1;
            if (k == 1) chk("zero_busy_t1", ctrl_busy, 1);
            if (k == 2) chk("zero_busy_t2", ctrl_busy, 0);
            if (k >= 1) chk("zero_done", ctrl_done, k == 2);
            chk("zero_arvalid", m_axi_arvalid, 0);
            chk("zero_tvalid", m_axis_tvalid, 0);
            chk("zero_rready", m_axi_rready, 0);
        end
        ctrl_start = 1'b0;
        m_axi_rvalid = 1'b0;

        for (int i = 0; i < 5; i++) run_xfer(vecs[i]);

        // Mid-transfer reset, then a short job must run cleanly.
        for (int k = 0; k < 8; k++) begin
            @(negedge ap_clk);
            ctrl_start = (k == 0);
            ctrl_addr = 64'h7000;
            ctrl_xfer_size = 32'd128;
            m_axi_arready = 1'b1;
            m_axis_tready = 1'b1;
        end
        ctrl_start = 1'b0;
        #1;
        chk("pre_reset_busy", ctrl_busy, 1);
        @(negedge ap_clk);
        areset = 1'b1;
        @(negedge ap_clk);
        areset = 1'b0;
        m_axi_rvalid = 1'b1;
        #1;
        chk("mid_rst_arvalid", m_axi_arvalid, 0);
        chk("mid_rst_rready", m_axi_rready, 0);
        chk("mid_rst_tvalid", m_axis_tvalid, 0);
        chk("mid_rst_tlast", m_axis_tlast, 0);
        chk("mid_rst_busy", ctrl_busy, 0);
        chk("mid_rst_done", ctrl_done, 0);
        chk("mid_rst_araddr", m_axi_araddr, 0);
        chk("mid_rst_arlen", m_axi_arlen, 0);
        m_axi_rvalid = 1'b0;

        run_xfer('{addr: 64'h8000, size: 32'd16, hold: 0, toggle: 0, mid: 0,
                   exp_beats: 4, exp_ars: 1, exp_last_len: 3});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/byteswap_axi_read_master.md
# byteswap_axi_read_master

AXI4 read master directly upstream of the byteswap datapath in the byteswap kernel. On a start pulse it reads `ctrl_xfer_size` bytes from global memory at `ctrl_addr` using INCR bursts with bounded outstanding requests. It presents the returned words in order as an AXI4-Stream to the swap stage, marks the final word with `tlast`, and pulses `ctrl_done` when the last word has been accepted.

## Interface
- `C_M_AXI_ADDR_WIDTH`, 64: AR address width.
- `C_M_AXI_DATA_WIDTH`, 32: R/stream data width; power of 2, ≥ 8. BPB = `C_M_AXI_DATA_WIDTH`/8 (bytes per beat).
- `C_XFER_SIZE_WIDTH`, 32: width of the byte count.
- `C_BURST_LEN`, 16: maximum beats per burst; power of 2, 1..256.
- `C_MAX_OUTSTANDING`, 4: maximum bursts issued but not yet completed by RLAST.

Ports:
- `ap_clk` in 1: sole clock; all logic on its rising edge.
- `areset` in 1: synchronous, active-high reset.
- `ctrl_start` in 1: single-cycle start pulse; ignored while busy.
- `ctrl_addr` in `C_M_AXI_ADDR_WIDTH`: byte base address; sampled on an accepted start.
- `ctrl_xfer_size` in `C_XFER_SIZE_WIDTH`: byte count; sampled on an accepted start.
- `ctrl_busy` out 1: high from an accepted start until `ctrl_done`.
- `ctrl_done` out 1: one-cycle completion pulse.
- `m_axi_arvalid` out 1, `m_axi_arready` in 1, `m_axi_araddr` out `C_M_AXI_ADDR_WIDTH`, `m_axi_arlen` out 8: AR channel.
- `m_axi_arsize` out 3: constant log2(BPB).
- `m_axi_arburst` out 2: constant 2'b01 (INCR).
- `m_axi_rvalid` in 1, `m_axi_rready` out 1, `m_axi_rdata` in `C_M_AXI_DATA_WIDTH`, `m_axi_rlast` in 1: R channel. `m_axi_rresp` and `m_axi_rid` are not consumed.
- `m_axis_tvalid` out 1, `m_axis_tready` in 1, `m_axis_tdata` out `C_M_AXI_DATA_WIDTH`, `m_axis_tlast` out 1: stream to the swap stage.

## Operation
- Total beats N = ceil(`ctrl_xfer_size`/BPB). A trailing partial word is read in full.
- Address alignment:
  - Base address low log2(BPB) bits are forced to zero.
  - The host places buffers on `C_BURST_LEN`*BPB boundaries, so no burst crosses 4 KiB.
- States:
  - IDLE: on `ctrl_start`, latch address and N. Go to RUN if N>0, else DONE.
  - RUN: issue AR bursts and forward R beats. Go to DONE after the beat that completes N.
  - DONE: assert `ctrl_done` for one cycle, return to IDLE.
- AR generation:
  - Each burst covers min(`C_BURST_LEN`, beats left to request); `arlen` = that count − 1.
  - `araddr` starts at base and advances by `C_BURST_LEN`*BPB per burst.
  - `arvalid` is held with address and length stable until `arready`.
  - `arvalid` is asserted only when outstanding < `C_MAX_OUTSTANDING` and beats remain to request.
- Outstanding counter:
  - +1 on AR handshake, −1 on R handshake with `rlast`; unchanged when both occur in the same cycle.
  - Range 0..`C_MAX_OUTSTANDING`.
- R to stream path, combinational pass-through:
  - `m_axis_tvalid` = `rvalid` & RUN.
  - `m_axi_rready` = `tready` & RUN.
  - `m_axis_tdata` = `rdata`.
- Stream ordering:
  - A beat counter advances on each stream handshake.
  - `tlast` is high exactly on beat N−1 (zero-based).
  - Internal bursts never produce `tlast`.
- `ctrl_start` in RUN or DONE is ignored, with no effect on latched values.
- Reset at any point:
  - Returns to IDLE and clears all counters.
  - In-flight R beats already requested are not drained; the system resets the interconnect together with this block.

## Timing
- Reset values:
  - `arvalid`=0, `rready`=0, `tvalid`=0, `tlast`=0, `ctrl_busy`=0, `ctrl_done`=0.
  - `araddr`=0, `arlen`=0.
- Start accepted in cycle T: `ctrl_busy` and `arvalid` (first burst) are high from T+1.
- Next AR is presentable the cycle after an AR handshake, subject to the outstanding limit.
- R to stream latency is 0 cycles, so throughput is 1 beat per cycle when `rvalid` and `tready` are both high.
- Final stream handshake in cycle L: `ctrl_done`=1 and `ctrl_busy`=0 in L+1. `ctrl_busy` stays high through L.
- N=0: start at T gives `ctrl_done` at T+2; no AR is issued and `ctrl_busy` is high only in T+1.

## Test plan
- 64 bytes at 0x1000, 32-bit data, `arready`/`rvalid`/`tready` always high -> one AR at `araddr`=0x1000, `arlen`=15; 16 stream beats on consecutive cycles; `tlast` on beat 16 only; `ctrl_done` one cycle after beat 16.
- 100 bytes at 0x2000 -> 25 beats; ARs at (0x2000, `arlen` 15) then (0x2040, `arlen` 8); `tlast` on beat 25; one `ctrl_done` pulse.
- Size 0 -> no `arvalid`; `ctrl_done` two cycles after start; stream stays idle.
- 512 bytes (8 bursts), `arready`=1, slave withholds R data for 20 cycles -> exactly 4 AR handshakes, then `arvalid` stays low until the first `rlast`. Then `tready` toggled 1/0 -> `rready` mirrors `tready`, data order is intact, 128 beats total.
- `ctrl_start` pulsed mid-transfer with a different address -> ignored; addresses and `tlast` follow the original request.
- `areset` asserted for one cycle mid-transfer -> every output at its reset value the next cycle. A following 16-byte start completes normally: `arlen`=3, 4 beats.
